// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment BCD conversion path.
package seg_pkg;

  // Conversion controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Largest value that fits on four decimal digits.
  localparam int unsigned BCD_MAX = 9999;

  // Blank mask shown while the digits hold their reset value of 0000:
  // thousands, hundreds and tens dark, ones digit lit.
  localparam logic [3:0] BLANK_RESET = 4'b1110;

  // Digit pattern shown when the value does not fit on the display.
  localparam logic [15:0] BCD_SAT = 16'h9999;

  // Leading-zero blanking mask for a packed digit word
  // ({thousands, hundreds, tens, ones}). The ones digit is never blanked,
  // and an overflowed (saturated) display is always fully lit.
  function automatic logic [3:0] lz_blank_mask(input logic [15:0] digits,
                                               input logic        ovf,
                                               input logic        enable);
    logic [3:0] mask;
    mask = 4'b0000;
    if (enable && !ovf) begin
      mask[3] = (digits[15:12] == 4'd0);
      mask[2] = mask[3] && (digits[11:8] == 4'd0);
      mask[1] = mask[2] && (digits[7:4] == 4'd0);
      mask[0] = 1'b0;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5
// or more, so the following left shift carries correctly into the next
// decimal digit. Pure 4-bit arithmetic, no carry out.
module bcd_add3_nibble (
  input  logic [3:0] in_nib,
  output logic [3:0] out_nib
);

  // Conditional +3 correction.
  always_comb begin
    out_nib = (in_nib >= 4'd5) ? (in_nib + 4'd3) : in_nib;
  end

endmodule

// File: rtl/seg_bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter feeding four bcd_7segment decoders.
// A value is accepted over valid/ready, converted one bit per cycle with
// shift-add-3, and the resulting digits, blank mask and overflow flag are
// then held stable until the next conversion completes.
module seg_bcd_convert_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned IN_W     = 14,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_value,
  output logic            in_ready,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [3:0]      digit_1000,
  output logic [3:0]      digit_100,
  output logic [3:0]      digit_10,
  output logic [3:0]      digit_1,
  output logic [3:0]      blank
);

  localparam int unsigned CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
  localparam int unsigned IN_MAX = (32'd1 << IN_W) - 32'd1;
  // Narrow inputs can never exceed four digits, so the range check is
  // only kept when the input width can actually reach past 9999.
  localparam bit CHK_OVF = (IN_MAX > BCD_MAX);
  localparam logic [3:0] BLANK_INIT = BLANK_LZ ? BLANK_RESET : 4'b0000;

  generate
    if (IN_W < 4 || IN_W > 14) begin : g_bad_in_w
      $error("seg_bcd_convert_ctrl: IN_W must be within 4..14");
    end
  endgenerate

  // Controller and datapath state.
  state_e            state_q,    state_d;
  logic [IN_W-1:0]   sh_q,       sh_d;
  logic [15:0]       acc_q,      acc_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              ovf_pend_q, ovf_pend_d;

  // Registered, externally visible results.
  logic [15:0]       digits_q,   digits_d;
  logic              ovf_q,      ovf_d;
  logic [3:0]        blank_q,    blank_d;
  logic              done_q,     done_d;

  // Accumulator with every nibble corrected ahead of the next shift.
  logic [15:0]       acc_corr;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_add3
      bcd_add3_nibble u_add3 (
        .in_nib  (acc_q[4*gi +: 4]),
        .out_nib (acc_corr[4*gi +: 4])
      );
    end
  endgenerate

  // Next-state and datapath update for the three-state conversion FSM.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    blank_d    = blank_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready is implied here: rst overrides everything in the flops.
        if (in_valid) begin
          sh_d       = in_value;
          acc_d      = 16'h0000;
          cnt_d      = '0;
          ovf_pend_d = CHK_OVF && (32'(in_value) > BCD_MAX);
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        // Correct, then shift {acc, sh} left by one bit.
        acc_d = {acc_corr[14:0], sh_q[IN_W-1]};
        sh_d  = {sh_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = LATCH;
        end
      end

      LATCH: begin
        // Out-of-range values saturate; acc may have wrapped in that case.
        digits_d = ovf_pend_q ? BCD_SAT : acc_q;
        ovf_d    = ovf_pend_q;
        blank_d  = lz_blank_mask(digits_d, ovf_pend_q, BLANK_LZ);
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset; reset also aborts
  // an in-flight conversion without producing a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      acc_q      <= 16'h0000;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= 16'h0000;
      ovf_q      <= 1'b0;
      blank_q    <= BLANK_INIT;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      blank_q    <= blank_d;
      done_q     <= done_d;
    end
  end

  // Output mapping; in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready   = (state_q == IDLE) && !rst;
    busy       = (state_q != IDLE);
    done       = done_q;
    ovf        = ovf_q;
    blank      = blank_q;
    digit_1000 = digits_q[15:12];
    digit_100  = digits_q[11:8];
    digit_10   = digits_q[7:4];
    digit_1    = digits_q[3:0];
  end

endmodule

// File: tb/tb_seg_bcd_convert_ctrl.sv
// Directed bench for seg_bcd_convert_ctrl: accepted values are modelled
// with decimal arithmetic into a scoreboard queue and compared when done
// pulses; reset, hold, abort and busy-handshake behaviour checked inline.
module tb_seg_bcd_convert_ctrl;

  localparam int IN_W = 14;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [IN_W-1:0] in_value = '0;
  logic            in_ready, busy, done, ovf;
  logic [3:0]      digit_1000, digit_100, digit_10, digit_1, blank;

  seg_bcd_convert_ctrl #(.IN_W(IN_W), .BLANK_LZ(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_value   (in_value),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .digit_1000 (digit_1000),
    .digit_100  (digit_100),
    .digit_10   (digit_10),
    .digit_1    (digit_1),
    .blank      (blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          value;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        ovf;
    int          accept_edge;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cnt = 0;
  int done_cnt = 0;

  function automatic exp_t model(input int v, input int acc_edge);
    exp_t e;
    logic [3:0] d3, d2, d1, d0;
    e.value = v;
    e.accept_edge = acc_edge;
    if (v > 9999) begin
      e.digits = 16'h9999;
      e.ovf    = 1'b1;
      e.blank  = 4'b0000;
    end else begin
      d3 = 4'(v / 1000);
      d2 = 4'((v / 100) % 10);
      d1 = 4'((v / 10) % 10);
      d0 = 4'(v % 10);
      e.digits = {d3, d2, d1, d0};
      e.ovf    = 1'b0;
      e.blank[3] = (d3 == 4'd0);
      e.blank[2] = e.blank[3] && (d2 == 4'd0);
      e.blank[1] = e.blank[2] && (d1 == 4'd0);
      e.blank[0] = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pop and compare on done, push model results on acceptance.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("digits", {digit_1000, digit_100, digit_10, digit_1}, mon_e.digits);
          chk("blank", blank, mon_e.blank);
          chk("ovf", ovf, mon_e.ovf);
          chk("latency", cyc - mon_e.accept_edge, IN_W + 1);
          chk("done_in_ready", in_ready, 1'b1);
          chk("done_busy", busy, 1'b0);
          $display("txn value=%0d digits=%h blank=%b ovf=%b", mon_e.value,
                   {digit_1000, digit_100, digit_10, digit_1}, blank, ovf);
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        sb.push_back(model(int'(in_value), cyc + 1));
        accept_cnt++;
      end
    end
  end

  task automatic wait_accept(input int target);
    int n = 0;
    while (accept_cnt < target && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("accept_wait", accept_cnt >= target, 1'b1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("done_wait", done_cnt >= target, 1'b1);
  endtask

  task automatic send(input int v);
    int a, d;
    a = accept_cnt;
    d = done_cnt;
    in_valid = 1'b1;
    in_value = IN_W'(v);
    wait_accept(a + 1);
    in_valid = 1'b0;
    wait_done(d + 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digits"}, {digit_1000, digit_100, digit_10, digit_1}, 16'h0000);
    chk({tag, "_blank"}, blank, 4'b1110);
    chk({tag, "_ovf"}, ovf, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, d;

    // Reset state, with in_ready held low during reset.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #2;
    chk("idle_in_ready", in_ready, 1'b1);

    // Single conversions across blanking and overflow boundaries.
    send(1234);
    send(0);
    send(7);
    send(45);
    send(9999);
    send(10000);
    send(16383);

    // Back-to-back: second value accepted in the done cycle of the first.
    a = accept_cnt;
    d = done_cnt;
    in_valid = 1'b1;
    in_value = IN_W'(1234);
    wait_accept(a + 1);
    in_value = IN_W'(5678);
    wait_done(d + 1);
    in_valid = 1'b0;
    chk("b2b_accept", accept_cnt, a + 2);
    repeat (5) begin
      @(posedge clk); #2;
      chk("b2b_hold", {digit_1000, digit_100, digit_10, digit_1}, 16'h1234);
      chk("b2b_busy", busy, 1'b1);
    end
    wait_done(d + 2);

    // Reset during the 5th SHIFT cycle aborts without a done pulse.
    a = accept_cnt;
    d = done_cnt;
    in_valid = 1'b1;
    in_value = IN_W'(4321);
    wait_accept(a + 1);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    chk_reset_outputs("abort");
    repeat (20) @(posedge clk);
    #2;
    chk("abort_no_done", done_cnt, d);
    send(88);

    // Toggle in_value while busy: result follows the captured value and
    // in_ready stays low until the conversion finishes.
    a = accept_cnt;
    d = done_cnt;
    in_valid = 1'b1;
    in_value = IN_W'(3141);
    wait_accept(a + 1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (!busy) break;
      chk("busy_in_ready", in_ready, 1'b0);
      in_value = IN_W'($urandom_range(0, 16383));
    end
    wait_accept(a + 2);
    in_valid = 1'b0;
    wait_done(d + 2);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_bcd_convert_ctrl.md
Name: seg_bcd_convert_ctrl

Overview:
Sequential binary-to-BCD conversion controller for the 4-digit 7-segment display path.
- Accepts a binary value over a valid/ready handshake.
- Runs an iterative shift-add-3 (double-dabble) conversion, one bit per cycle, so no combinational dividers are needed.
- Holds the four resulting BCD digits, blanking mask and overflow flag stable for the per-digit bcd_7segment decoders.
- Sits between the value source (switches / ALU result) and the four bcd_7segment instances.

Parameters:
IN_W, 14, binary input width; legal range 4..14.
BLANK_LZ, 1, 1 = blank leading-zero digits; 0 = never blank.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_value is presented for conversion
in_value  input  IN_W  unsigned binary value
in_ready  output  1  block can accept a value this cycle
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: new digits valid this cycle
ovf  output  1  last accepted value > 9999
digit_1000  output  4  BCD thousands
digit_100  output  4  BCD hundreds
digit_10  output  4  BCD tens
digit_1  output  4  BCD ones
blank  output  4  per-digit blank, bit3 = thousands .. bit0 = ones

Behaviour:
Interface:
- One clock (clk); reset (rst) is synchronous and active-high.

Reset:
- Outputs: all digits 0, ovf 0, done 0, busy 0, state IDLE.
- blank = 4'b1110 if BLANK_LZ=1, else 4'b0000.
- in_ready = 0 while rst is high.

States:
- IDLE: in_ready=1, busy=0. On in_valid & in_ready, capture in_value into shift register sh, clear BCD accumulator acc[15:0], bit counter cnt=0, go to SHIFT.
- SHIFT: busy=1, in_ready=0. Each cycle:
  - every acc nibble >= 5 gets +3;
  - then {acc,sh} shifts left by 1;
  - cnt++.
  - After the IN_W-th shift, go to LATCH.
- LATCH: busy=1. Register the output digits, ovf and blank, then go to IDLE. done=1 in the cycle after this edge.

Latency and hold rules:
- Acceptance on edge E0; done high and outputs updated in the cycle following edge E0+IN_W+1.
- Outputs hold previous values throughout conversion; no intermediate values are visible.

Overflow:
- If the captured value > 9999 (check evaluated only when 2^IN_W-1 > 9999): ovf=1 and digits forced to 9,9,9,9.
- Conversion cycles still run, so latency is constant.
- Otherwise ovf=0.

Blanking (BLANK_LZ=1):
- blank[3]=1 iff digit_1000==0.
- blank[2]=1 iff blank[3] & digit_100==0.
- blank[1]=1 iff blank[2] & digit_10==0.
- blank[0] is always 0.
- When ovf=1, blank=0.

Handshake and boundary cases:
- in_valid while busy is ignored; the requester holds the value until in_ready.
- done and in_ready are both high in the cycle after LATCH; a new acceptance in that cycle is legal, so back-to-back throughput is one value per IN_W+2 cycles.
- rst mid-conversion aborts: state returns to IDLE, outputs take reset values, and no done is issued.
- in_value changes after acceptance have no effect.

Width rules:
- acc is 16 bits; nibble correction is 4-bit unsigned, no carry between nibbles.
- cnt width is clog2(IN_W+1).

Decomposition:
Shared package seg_pkg:
- state enum (IDLE, SHIFT, LATCH);
- constant BCD_MAX = 9999;
- constant BLANK_RESET = 4'b1110.

Sub-module bcd_add3_nibble:
- combinational; out = (in >= 5) ? in+3 : in;
- instantiated 4 times on acc.
Output digits connect directly to the existing bcd_7segment instances.

Test Plan:
- After reset, in_valid=1, in_value=1234 -> done pulses exactly 16 cycles after acceptance; digits 1,2,3,4; blank=0000; ovf=0.
- in_value=0 -> digits 0,0,0,0; blank=1110. in_value=7 -> blank=1110, digit_1=7. in_value=45 -> blank=1100.
- in_value=9999 -> digits 9,9,9,9; ovf=0. in_value=10000 and 16383 -> digits 9,9,9,9; ovf=1; blank=0000.
- Hold in_valid=1 with values 1234 then 5678 -> second acceptance in the done cycle. During the second conversion, outputs stay at 1234; the second done shows 5,6,7,8.
- Assert rst for 1 cycle at the 5th SHIFT cycle of value 4321 -> outputs return to reset values, no done pulse; a subsequent value 88 converts correctly (blank=1100).
- Toggle in_value while busy=1 -> result matches the value captured at acceptance; in_ready stays 0 until conversion completes.
